ram_init: RTL and testbench

Parametrised synchronous RAM with a built-in power-up initialisation sequencer. After reset release, or on request, it sweeps every address once and writes the C64-style DRAM power-on pattern: alternating runs of a low and a high fill value. During the sweep, host accesses are blocked and `busy` is asserted. It replaces ad-hoc reset-muxed RAM wrappers for main and colour RAM, and instantiates the existing `ram` primitive for storage.

---
 rtl/ram_init_pkg.sv | 28 ++
 rtl/ram_init_ram.sv | 35 +++
 rtl/ram_init.sv | 135 +++++++++++++
 tb/tb_ram_init.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_init_pkg.sv
// ram_init_pkg: shared types and helpers for the ram_init block.
//   state_t      - sequencer state (INIT sweep / READY for host access)
//   init_pattern - power-on fill value for a given address
package ram_init_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Widest address/data the helper accepts. Callers size-cast in and out.
  localparam int MAX_AW = 32;
  localparam int MAX_DW = 64;

  // Bit RUN_SHIFT of the address selects the run. Even runs get the low
  // fill value and odd runs get the high fill value.
  function automatic logic [MAX_DW-1:0] init_pattern(
    input logic [MAX_AW-1:0] addr,
    input int                run_shift,
    input logic [MAX_DW-1:0] pat_lo,
    input logic [MAX_DW-1:0] pat_hi
  );
    logic [MAX_AW-1:0] shifted;
    shifted = addr >> run_shift;
    return shifted[0] ? pat_hi : pat_lo;
  endfunction

endpackage

// File: rtl/ram_init_ram.sv
// ram: single-port synchronous RAM. The read is registered and happens
// before the write (read-before-write).
// Ports:
//   i_clk   clock
//   i_en    access enable (read and write)
//   i_we    write enable, qualified by i_en
//   i_addr  address
//   i_di    write data
//   o_do    read data, registered, holds when i_en=0
module ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_di,
  output logic [DATA_WIDTH-1:0] o_do
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_di;
      end
      o_do <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/ram_init.sv
// ram_init: synchronous RAM with a power-up initialisation sequencer.
// After reset release (when INIT_ON_RESET=1), or after an init request, it
// sweeps every address once. The fill pattern is alternating runs of PAT_LO
// and PAT_HI, each 2^RUN_SHIFT words long. Host access is blocked while the
// sweep is running.
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous reset, active low
//   i_enable    host access enable
//   i_we        host write enable, qualified by i_enable
//   i_a         host address
//   i_di        host write data
//   o_do        host read data, 1-cycle latency, 0 while sweeping
//   i_init_req  one-cycle request to re-run the sweep (ignored while sweeping)
//   o_busy      1 while the sweep is in progress
//   o_done      one-cycle pulse on the first READY cycle after a sweep
//
// state | meaning
// INIT  | sweeping: writes the pattern to r_cnt each cycle, host blocked
// READY | RAM driven directly by the host port
module ram_init
  import ram_init_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    RUN_SHIFT     = 6,
  parameter logic [DATA_WIDTH-1:0] PAT_LO        = '0,
  parameter logic [DATA_WIDTH-1:0] PAT_HI        = '1,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_di,
  output logic [DATA_WIDTH-1:0] o_do,
  input  logic                  i_init_req,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam state_t                RST_STATE = INIT_ON_RESET ? INIT : READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_done;
  // Set once the host has issued a read in READY. It masks the stale RAM
  // output register, which was last loaded by a sweep read or not at all.
  logic                  r_rd_valid;

  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_a;
  logic [DATA_WIDTH-1:0] w_ram_di;
  logic [DATA_WIDTH-1:0] w_ram_do;
  logic [DATA_WIDTH-1:0] w_pat;

  assign w_pat = DATA_WIDTH'(init_pattern(MAX_AW'(r_cnt), RUN_SHIFT,
                                          MAX_DW'(PAT_LO), MAX_DW'(PAT_HI)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RST_STATE;
      r_cnt      <= '0;
      r_busy     <= INIT_ON_RESET;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        INIT: begin
          r_rd_valid <= 1'b0;
          r_cnt      <= r_cnt + ADDR_WIDTH'(1);
          if (r_cnt == LAST_ADDR) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        READY: begin
          if (i_init_req) begin
            r_state    <= INIT;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
          end else if (i_enable) begin
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= RST_STATE;
        end
      endcase
    end
  end

  // Reset gates the RAM so that nothing is written while i_rst_n is low.
  always_comb begin
    w_ram_en = 1'b0;
    w_ram_we = 1'b0;
    w_ram_a  = i_a;
    w_ram_di = i_di;
    if (i_rst_n) begin
      if (r_state == INIT) begin
        w_ram_en = 1'b1;
        w_ram_we = 1'b1;
        w_ram_a  = r_cnt;
        w_ram_di = w_pat;
      end else begin
        w_ram_en = i_enable;
        w_ram_we = i_we;
      end
    end
  end

  ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_a),
    .i_di   (w_ram_di),
    .o_do   (w_ram_do)
  );

  assign o_do   = r_rd_valid ? w_ram_do : '0;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_ram_init.sv
module tb_ram_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with sweep after reset
  logic       rst_n = 1'b0;
  logic       en = 1'b0, we = 1'b0, req = 1'b0;
  logic [7:0] a = 8'h00, di = 8'h00;
  logic [7:0] dout;
  logic       busy, done;

  // DUT entering READY directly from reset
  logic       rst0_n = 1'b0;
  logic       en0 = 1'b0, we0 = 1'b0, req0 = 1'b0;
  logic [7:0] a0 = 8'h00, di0 = 8'h00;
  logic [7:0] dout0;
  logic       busy0, done0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  ram_init #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RUN_SHIFT(2),
    .PAT_LO(8'h00), .PAT_HI(8'hFF), .INIT_ON_RESET(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_we(we), .i_a(a),
    .i_di(di), .o_do(dout), .i_init_req(req), .o_busy(busy), .o_done(done)
  );

  ram_init #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RUN_SHIFT(2),
    .PAT_LO(8'h00), .PAT_HI(8'hFF), .INIT_ON_RESET(1'b0)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_enable(en0), .i_we(we0), .i_a(a0),
    .i_di(di0), .o_do(dout0), .i_init_req(req0), .o_busy(busy0), .o_done(done0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos: next sweep address, or -1 when the host owns the RAM
  int         m_pos  = 0;
  bit [7:0]   m_mem [256];
  bit         m_done = 1'b0;
  bit         m_seen = 1'b0;
  bit [7:0]   m_rd   = 8'h00;

  function automatic bit [7:0] pattern(input int addr);
    return ((addr / 4) % 2 == 1) ? 8'hFF : 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  = 0;
      m_done = 1'b0;
      m_seen = 1'b0;
    end else if (m_pos >= 0) begin
      m_mem[m_pos] = pattern(m_pos);
      m_seen = 1'b0;
      m_done = (m_pos == 255);
      m_pos  = m_done ? -1 : m_pos + 1;
    end else begin
      m_done = 1'b0;
      if (en) begin
        m_rd = m_mem[a];
        if (we) m_mem[a] = di;
      end
      if (req) begin
        m_pos  = 0;
        m_seen = 1'b0;
      end else if (en) begin
        m_seen = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'b0, busy}, {31'b0, m_pos >= 0});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("do",   {24'b0, dout}, {24'b0, m_seen ? m_rd : 8'h00});
    end
  end

  // dut0 must never be busy and never pulse done
  int n_busy0 = 0;
  int n_done0 = 0;
  always @(negedge clk) begin
    if (busy0) n_busy0++;
    if (done0) n_done0++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string nm);
    @(posedge clk); #1;
    en = 1'b1; we = 1'b0; a = addr;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    chk(nm, {24'b0, dout}, {24'b0, exp});
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    en = 1'b1; we = 1'b1; a = addr; di = data;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  // Counts busy cycles until done; optionally drops a held host access and
  // fires one init_req at given busy counts.
  task automatic wait_done(input int start, input int drop_at, input int req_at,
                           output int busy_n, output int done_n);
    busy_n = start;
    done_n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        break;
      end
      if (busy_n == drop_at) begin
        en = 1'b0; we = 1'b0;
      end
      req = (busy_n == req_at);
    end
    req = 1'b0;
  endtask

  int bn, dn;

  initial begin
    chk_on = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_do",   {24'b0, dout}, 32'd0);

    // release; host hammers a write to 0x10 during the sweep
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1; we = 1'b1; a = 8'h10; di = 8'hAA;
    wait_done(0, 10, -1, bn, dn);
    chk("sweep1_len",  bn, 256);
    chk("sweep1_done", dn, 1);
    @(negedge clk);
    chk("done_once", {31'b0, done}, 32'd0);

    // pattern readback
    for (int i = 0; i < 8; i++)
      rd(8'(i), (i < 4) ? 8'h00 : 8'hFF, "pat_lo_hi");
    for (int i = 252; i < 256; i++)
      rd(8'(i), 8'hFF, "pat_top");
    rd(8'h10, 8'h00, "dropped_write");

    // host write then read
    wr(8'h03, 8'h5A);
    rd(8'h03, 8'h5A, "wr_rd");

    // read-before-write on the same edge
    @(posedge clk); #1;
    en = 1'b1; we = 1'b1; a = 8'h03; di = 8'h33;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rbw_old", {24'b0, dout}, 32'h5A);
    rd(8'h03, 8'h33, "rbw_new");

    // reset in the middle of a sweep
    @(posedge clk); #1; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done(0, -1, -1, bn, dn);
    chk("sweep2_len",  bn, 256);
    chk("sweep2_done", dn, 1);
    rd(8'h03, 8'h00, "abort_rewrite");

    // write, then write plus init_req in the same cycle, plus mid-sweep req
    wr(8'h04, 8'h77);
    rd(8'h04, 8'h77, "pre_req");
    @(posedge clk); #1;
    en = 1'b1; we = 1'b1; a = 8'h05; di = 8'h77; req = 1'b1;
    @(negedge clk);
    chk("busy_before", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("busy_rise", {31'b0, busy}, 32'd1);
    wait_done(1, -1, 50, bn, dn);
    chk("sweep3_len",  bn, 256);
    chk("sweep3_done", dn, 1);
    rd(8'h04, 8'hFF, "reinit_04");
    rd(8'h05, 8'hFF, "reinit_05");
    rd(8'h00, 8'h00, "reinit_00");

    // INIT_ON_RESET=0
    @(negedge clk);
    chk("r0_rst_busy", {31'b0, busy0}, 32'd0);
    chk("r0_rst_do",   {24'b0, dout0}, 32'd0);
    @(posedge clk); #1;
    rst0_n = 1'b1;
    en0 = 1'b1; we0 = 1'b1; a0 = 8'h20; di0 = 8'h42;
    @(negedge clk);
    chk("r0_busy", {31'b0, busy0}, 32'd0);
    chk("r0_do0",  {24'b0, dout0}, 32'd0);
    @(posedge clk); #1;
    we0 = 1'b0;
    @(posedge clk); #1;
    en0 = 1'b0;
    @(negedge clk);
    chk("r0_wr_rd", {24'b0, dout0}, 32'h42);
    repeat (20) @(negedge clk);
    chk("r0_hold", {24'b0, dout0}, 32'h42);
    chk("r0_no_busy", n_busy0, 0);
    chk("r0_no_done", n_done0, 0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
